// File: rtl/fft_frame_loader.sv
`default_nettype none
// ============================================================================
// fft_frame_loader : assembles 8 streamed complex samples into one fft core frame
// Revision 1.0
// ============================================================================
module fft_frame_loader #(
   parameter int DW          = 32,
   parameter int STR_LEN     = 1,
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_real,
   input  logic [DW-1:0] in_imag,
   input  logic          in_last,
   input  logic          in_mode,
   output logic [DW-1:0] real_x0,
   output logic [DW-1:0] real_x1,
   output logic [DW-1:0] real_x2,
   output logic [DW-1:0] real_x3,
   output logic [DW-1:0] real_x4,
   output logic [DW-1:0] real_x5,
   output logic [DW-1:0] real_x6,
   output logic [DW-1:0] real_x7,
   output logic [DW-1:0] imag_x0,
   output logic [DW-1:0] imag_x1,
   output logic [DW-1:0] imag_x2,
   output logic [DW-1:0] imag_x3,
   output logic [DW-1:0] imag_x4,
   output logic [DW-1:0] imag_x5,
   output logic [DW-1:0] imag_x6,
   output logic [DW-1:0] imag_x7,
   output logic          switch,
   output logic          str_sig,
   input  logic          done_sig,
   input  logic          error,
   output logic          frame_err,
   output logic          timeout,
   output logic          core_err,
   output logic [15:0]   frame_cnt
);

   localparam logic [11:0] C_STR_LAST = 12'(STR_LEN - 1);
   localparam logic [11:0] C_TIMEOUT  = 12'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_FILL      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_DRAIN     = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_idx;
   logic [11:0]   r_cnt;
   logic          r_pend_mode;
   logic [DW-1:0] r_re [8];
   logic [DW-1:0] r_im [8];
   logic          w_xfer;
   logic          w_good_last;
   logic          w_bad;
   logic          w_done_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FILL;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      str_sig     = 1'b0;
      timeout     = 1'b0;
      w_xfer      = 1'b0;
      w_good_last = 1'b0;
      w_bad       = 1'b0;
      w_done_hit  = 1'b0;
      case (r_state)
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_xfer = 1'b1;
               if (r_idx == 3'd7) begin
                  if (in_last) begin
                     w_good_last = 1'b1;
                     w_state_nxt = S_START;
                  end else begin
                     w_bad = 1'b1;
                  end
               end else if (in_last) begin
                  w_bad = 1'b1;
               end
            end
         end
         S_START: begin
            str_sig = 1'b1;
            if (r_cnt == C_STR_LAST) w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // done_sig wins over a timeout landing in the same cycle
            if (done_sig) begin
               w_done_hit  = 1'b1;
               w_state_nxt = S_DRAIN;
            end else if (r_cnt == C_TIMEOUT) begin
               timeout     = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         S_DRAIN: begin
            if (!done_sig) w_state_nxt = S_FILL;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= 3'd0;
         r_cnt       <= 12'd0;
         r_pend_mode <= 1'b1;
         switch      <= 1'b1;
         frame_err   <= 1'b0;
         core_err    <= 1'b0;
         frame_cnt   <= 16'd0;
         for (int i = 0; i < 8; i++) begin
            r_re[i] <= '0;
            r_im[i] <= '0;
         end
      end else begin
         frame_err <= w_bad;
         // Counter restarts on every state change, so START and WAIT_DONE each count from 0
         if (w_state_nxt != r_state)
            r_cnt <= 12'd0;
         else if (r_state == S_START || r_state == S_WAIT_DONE)
            r_cnt <= r_cnt + 12'd1;
         if (w_xfer) begin
            r_re[r_idx] <= in_real;
            r_im[r_idx] <= in_imag;
            if (r_idx == 3'd0) r_pend_mode <= in_mode;
            r_idx <= (w_bad || w_good_last) ? 3'd0 : r_idx + 3'd1;
         end
         if (w_good_last) switch <= r_pend_mode;
         if (w_done_hit) begin
            core_err  <= core_err | error;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign real_x0 = r_re[0];
   assign real_x1 = r_re[1];
   assign real_x2 = r_re[2];
   assign real_x3 = r_re[3];
   assign real_x4 = r_re[4];
   assign real_x5 = r_re[5];
   assign real_x6 = r_re[6];
   assign real_x7 = r_re[7];
   assign imag_x0 = r_im[0];
   assign imag_x1 = r_im[1];
   assign imag_x2 = r_im[2];
   assign imag_x3 = r_im[3];
   assign imag_x4 = r_im[4];
   assign imag_x5 = r_im[5];
   assign imag_x6 = r_im[6];
   assign imag_x7 = r_im[7];

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_loader : randomized frame-level bench with a behavioural model
// Revision 1.0
// ============================================================================
module tb_fft_frame_loader;

   localparam int DW          = 32;
   localparam int STR_LEN     = 1;
   localparam int TIMEOUT_CYC = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_mode = 1'b0;
   logic          done_sig = 1'b0;
   logic          error = 1'b0;
   logic [DW-1:0] in_real = '0;
   logic [DW-1:0] in_imag = '0;
   logic          in_ready, switch, str_sig, frame_err, timeout, core_err;
   logic [15:0]   frame_cnt;
   logic [DW-1:0] real_x0, real_x1, real_x2, real_x3, real_x4, real_x5, real_x6, real_x7;
   logic [DW-1:0] imag_x0, imag_x1, imag_x2, imag_x3, imag_x4, imag_x5, imag_x6, imag_x7;

   always #5 clk = ~clk;

   fft_frame_loader #(.DW(DW), .STR_LEN(STR_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .in_mode(in_mode),
      .real_x0(real_x0), .real_x1(real_x1), .real_x2(real_x2), .real_x3(real_x3),
      .real_x4(real_x4), .real_x5(real_x5), .real_x6(real_x6), .real_x7(real_x7),
      .imag_x0(imag_x0), .imag_x1(imag_x1), .imag_x2(imag_x2), .imag_x3(imag_x3),
      .imag_x4(imag_x4), .imag_x5(imag_x5), .imag_x6(imag_x6), .imag_x7(imag_x7),
      .switch(switch), .str_sig(str_sig), .done_sig(done_sig), .error(error),
      .frame_err(frame_err), .timeout(timeout), .core_err(core_err), .frame_cnt(frame_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what the core should currently see
   logic [DW-1:0] m_re [8];
   logic [DW-1:0] m_im [8];
   logic          m_switch;
   logic          m_core_err;
   logic [15:0]   m_cnt;
   logic [DW-1:0] stim_re [8];
   logic [DW-1:0] stim_im [8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] get_re(input int i);
      case (i)
         0: return real_x0; 1: return real_x1; 2: return real_x2; 3: return real_x3;
         4: return real_x4; 5: return real_x5; 6: return real_x6; default: return real_x7;
      endcase
   endfunction

   function automatic logic [DW-1:0] get_im(input int i);
      case (i)
         0: return imag_x0; 1: return imag_x1; 2: return imag_x2; 3: return imag_x3;
         4: return imag_x4; 5: return imag_x5; 6: return imag_x6; default: return imag_x7;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_re[i] = '0;
         m_im[i] = '0;
      end
      m_switch   = 1'b1;
      m_core_err = 1'b0;
      m_cnt      = 16'd0;
   endtask

   task automatic check_frame(input string tag);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_re"}, get_re(i), m_re[i]);
         check({tag, "_im"}, get_im(i), m_im[i]);
      end
      check({tag, "_switch"}, switch, m_switch);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, in_ready, 1'b1);
      check({tag, "_str"}, str_sig, 1'b0);
      check({tag, "_ferr"}, frame_err, 1'b0);
      check({tag, "_tmo"}, timeout, 1'b0);
      check({tag, "_cerr"}, core_err, m_core_err);
      check({tag, "_fcnt"}, frame_cnt, m_cnt);
   endtask

   task automatic rand_stim();
      for (int i = 0; i < 8; i++) begin
         stim_re[i] = $urandom;
         stim_im[i] = $urandom;
      end
   endtask

   // n samples offered, in_last on index last_at (-1: never); fin 0: done handshake, 1: timeout
   task automatic do_frame(input int n, input int last_at, input bit mode, input int fin, input bit err);
      int  sent;
      int  dly;
      bit  good;
      sent = 0;
      good = (n == 8) && (last_at == 7);
      while (sent < n) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            in_mode  = 1'($urandom);
            in_real  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_real  = stim_re[sent];
            in_imag  = stim_im[sent];
            in_last  = (sent == last_at);
            in_mode  = (sent == 0) ? mode : 1'($urandom);
         end
         #3;
         check("ready_fill", in_ready, 1'b1);
         if (in_valid) begin
            m_re[sent] = stim_re[sent];
            m_im[sent] = stim_im[sent];
            sent++;
         end
      end
      @(posedge clk); #1;
      in_valid = good;
      in_last  = 1'b0;
      in_real  = $urandom;
      in_imag  = $urandom;
      #3;
      if (!good) begin
         check("frame_err", frame_err, 1'b1);
         check("str_bad", str_sig, 1'b0);
         check("ready_bad", in_ready, 1'b1);
         check_frame("drop");
         @(posedge clk); #4;
         check("frame_err_end", frame_err, 1'b0);
         check("str_bad2", str_sig, 1'b0);
         return;
      end
      m_switch = mode;
      for (int k = 0; k < STR_LEN; k++) begin
         if (k > 0) begin
            @(posedge clk); #4;
         end
         check("str_sig", str_sig, 1'b1);
         check("ready_start", in_ready, 1'b0);
         check_frame("start");
      end
      dly = (fin == 0) ? $urandom_range(0, TIMEOUT_CYC - 1) : TIMEOUT_CYC + 10;
      for (int k = 0; k <= TIMEOUT_CYC; k++) begin
         @(posedge clk); #1;
         done_sig = (k == dly);
         error    = (k == dly) ? err : 1'($urandom);
         in_real  = $urandom;
         #3;
         check("str_low", str_sig, 1'b0);
         check("ready_wait", in_ready, 1'b0);
         check("timeout", timeout, (fin == 1) && (k == TIMEOUT_CYC));
         if (k == dly) break;
      end
      if (fin == 0) begin
         m_cnt      = m_cnt + 16'd1;
         m_core_err = m_core_err | err;
         for (int h = $urandom_range(0, 3); h > 0; h--) begin
            @(posedge clk); #1;
            error = 1'($urandom);
            #3;
            check("ready_drain", in_ready, 1'b0);
            check("fcnt_drain", frame_cnt, m_cnt);
            check("cerr_drain", core_err, m_core_err);
         end
         @(posedge clk); #1;
         done_sig = 1'b0;
         error    = 1'b0;
         #3;
         check("ready_drain_exit", in_ready, 1'b0);
         check_frame("drain");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      done_sig = 1'b0;
      error    = 1'b0;
      #3;
      check_idle("after");
      check_frame("after");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int last_at;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      check_idle("reset");
      check_frame("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      rand_stim();
      stim_re[0] = 32'h4040_0000; stim_im[0] = 32'h3f80_0000;
      stim_re[1] = 32'h4080_0000; stim_im[1] = 32'hc000_0000;
      do_frame(8, 7, 1'b1, 0, 1'b0);
      check("fft_real_x0", real_x0, 32'h4040_0000);
      check("fft_imag_x1", imag_x1, 32'hc000_0000);
      check("fft_frame_cnt", frame_cnt, 16'd1);

      rand_stim();
      do_frame(8, 7, 1'b0, 0, 1'b0);
      check("ifft_switch", switch, 1'b0);

      rand_stim();
      do_frame(5, 4, 1'b1, 0, 1'b0);
      rand_stim();
      do_frame(8, 7, 1'b1, 0, 1'b0);
      rand_stim();
      do_frame(8, -1, 1'b0, 0, 1'b0);
      rand_stim();
      do_frame(8, 7, 1'b0, 0, 1'b0);

      for (int f = 0; f < 12; f++) begin
         rand_stim();
         case ($urandom_range(0, 3))
            0: begin
               last_at = $urandom_range(0, 6);
               do_frame(last_at + 1, last_at, 1'($urandom), 0, 1'b0);
            end
            1: do_frame(8, -1, 1'($urandom), 0, 1'b0);
            default: do_frame(8, 7, 1'($urandom), 0, 1'b0);
         endcase
      end

      rand_stim();
      do_frame(8, 7, 1'b1, 1, 1'b0);

      rand_stim();
      do_frame(8, 7, 1'b1, 0, 1'b1);
      check("core_err_set", core_err, 1'b1);
      rand_stim();
      do_frame(8, 7, 1'b0, 0, 1'b0);
      check("core_err_sticky", core_err, 1'b1);

      @(posedge clk); #1;
      force dut.frame_cnt = 16'hffff;
      #1;
      release dut.frame_cnt;
      m_cnt = 16'hffff;
      #2;
      check("fcnt_preload", frame_cnt, 16'hffff);
      rand_stim();
      do_frame(8, 7, 1'b1, 0, 1'b0);
      check("fcnt_wrap", frame_cnt, 16'h0000);

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_real  = $urandom | 32'h1;
         in_imag  = $urandom | 32'h1;
         in_last  = 1'b0;
         in_mode  = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_idle("midrst");
      check_frame("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rand_stim();
      do_frame(8, 7, 1'b1, 0, 1'b0);
      check("post_rst_cnt", frame_cnt, 16'd1);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
